// File: rtl/uart_fifo_mmio_if.sv
// MMIO bus bundle for the UART FIFO peripheral slot.
interface uart_fifo_mmio_if #(
  parameter int ADDR_W = 8
);
  logic              mmio_valid;
  logic              mmio_ready;
  logic              mmio_we;
  logic [ADDR_W-1:0] mmio_addr;
  logic [31:0]       mmio_wdata;
  logic [3:0]        mmio_wstrb;
  logic [31:0]       mmio_rdata;

  modport master (
    output mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
    input  mmio_ready, mmio_rdata
  );

  modport slave (
    input  mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
    output mmio_ready, mmio_rdata
  );
endinterface

// File: rtl/uart_fifo_mmio.sv
// MMIO UART controller: TX/RX FIFOs, IRQ thresholds, flush, loopback,
// sticky error flags, wrapped around a small 8N1 UART core.
module uart_fifo_mmio #(
  parameter int ADDR_W     = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int BAUD_DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx_i,
  output logic             uart_tx_o,
  uart_fifo_mmio_if.slave  bus,
  output logic             irq_o
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_FULL_CNT = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL_CNT = (RXA+1)'(RX_DEPTH);
  localparam logic [ADDR_W-3:0] OFF_DATA = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] OFF_STAT = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] OFF_CTRL = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] OFF_BAUD = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] OFF_LVL  = (ADDR_W-2)'(4);
  localparam logic [ADDR_W-3:0] OFF_THR  = (ADDR_W-2)'(5);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic tx_en, rx_en, irq_rx_en, irq_tx_en, loopback;
  logic [BAUD_DIV_W-1:0] baud_div, baud_wval;
  logic [7:0] rx_thr, tx_thr, rx_thr_eff;
  logic rx_ovr, tx_ovf, launch_q;
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TXA:0] tx_wp, tx_rp, tx_cnt;
  logic [RXA:0] rx_wp, rx_rp, rx_cnt;
  logic [15:0] tx_lvl, rx_lvl;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic [ADDR_W-3:0] off;
  logic wr, rd, ctrl_wr, stat_rd, tx_flush, rx_flush;
  logic tx_push, tx_wr, trmt, rx_push, rx_pop, rx_wr, clr_rx_rdy;
  logic [31:0] rdata;
  logic unused_ok;
  // UART core state
  logic tx_busy, tx_ready, tx_line;
  logic [9:0] tx_sh;
  logic [3:0] tx_bits;
  logic [BAUD_DIV_W-1:0] tx_tmr;
  logic rx_in, rx_s1, rx_s2, rx_rdy, rx_done;
  logic [7:0] rx_data, rx_sh, rx_sh_d;
  logic [2:0] rx_bit, rx_bit_d;
  logic [BAUD_DIV_W-1:0] rx_tmr, rx_tmr_d;
  rx_state_t rx_state, rx_state_d;

  assign unused_ok = ^{bus.mmio_addr[1:0], bus.mmio_wdata};

  assign off      = bus.mmio_addr[ADDR_W-1:2];
  assign wr       = bus.mmio_valid & bus.mmio_we;
  assign rd       = bus.mmio_valid & ~bus.mmio_we;
  assign ctrl_wr  = wr & (off == OFF_CTRL) & bus.mmio_wstrb[0];
  assign stat_rd  = rd & (off == OFF_STAT);
  assign tx_flush = ctrl_wr & bus.mmio_wdata[4];
  assign rx_flush = ctrl_wr & bus.mmio_wdata[5];
  assign bus.mmio_ready = 1'b1;

  assign tx_cnt   = tx_wp - tx_rp;
  assign rx_cnt   = rx_wp - rx_rp;
  assign tx_lvl   = 16'(tx_cnt);
  assign rx_lvl   = 16'(rx_cnt);
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULL_CNT);
  assign rx_full  = (rx_cnt == RX_FULL_CNT);
  assign tx_idle  = tx_empty & tx_ready;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign tx_push    = wr & (off == OFF_DATA) & bus.mmio_wstrb[0];
  assign trmt       = tx_en & ~tx_empty & tx_ready & ~launch_q;
  assign tx_wr      = tx_push & (~tx_full | trmt);
  assign rx_push    = rx_rdy & rx_en;
  assign rx_pop     = rd & (off == OFF_DATA) & ~rx_empty;
  assign rx_wr      = rx_push & (~rx_full | rx_pop);
  assign clr_rx_rdy = rx_push;

  assign rx_thr_eff = (rx_thr == 8'd0) ? 8'd1 : rx_thr;
  assign irq_o = (irq_rx_en & (rx_lvl >= {8'd0, rx_thr_eff})) |
                 (irq_tx_en & (tx_lvl <= {8'd0, tx_thr}));

  // Byte-strobed merge of a BAUD_DIV write onto the current divisor.
  always_comb begin
    baud_wval = baud_div;
    for (int i = 0; i < BAUD_DIV_W; i++)
      if (bus.mmio_wstrb[i/8]) baud_wval[i] = bus.mmio_wdata[i];
  end

  // Register read mux; rdata is valid combinationally in the fire cycle.
  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_DATA: if (!rx_empty) rdata = {24'd0, rx_mem[rx_rp[RXA-1:0]]};
      OFF_STAT: rdata = {26'd0, tx_ovf, rx_ovr, rx_full, tx_full, tx_idle, ~rx_empty};
      OFF_CTRL: rdata = {25'd0, loopback, 2'b00, irq_tx_en, irq_rx_en, rx_en, tx_en};
      OFF_BAUD: rdata = 32'(baud_div);
      OFF_LVL:  rdata = {tx_lvl, rx_lvl};
      OFF_THR:  rdata = {16'd0, tx_thr, rx_thr};
      default:  rdata = 32'd0;
    endcase
  end
  assign bus.mmio_rdata = rdata;

  // Control registers, sticky flags (set beats read-clear) and launch guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en <= 1'b1; rx_en <= 1'b1; irq_rx_en <= 1'b0; irq_tx_en <= 1'b0;
      loopback <= 1'b0; baud_div <= '0; rx_thr <= 8'd1; tx_thr <= 8'd0;
      rx_ovr <= 1'b0; tx_ovf <= 1'b0; launch_q <= 1'b0;
    end else begin
      launch_q <= trmt;
      rx_ovr <= (rx_push & rx_full & ~rx_pop) | (rx_ovr & ~stat_rd);
      tx_ovf <= (tx_push & tx_full & ~trmt) | (tx_ovf & ~stat_rd);
      if (ctrl_wr) begin
        tx_en     <= bus.mmio_wdata[0];
        rx_en     <= bus.mmio_wdata[1];
        irq_rx_en <= bus.mmio_wdata[2];
        irq_tx_en <= bus.mmio_wdata[3];
        loopback  <= bus.mmio_wdata[6];
      end
      if (wr && off == OFF_BAUD) baud_div <= baud_wval;
      if (wr && off == OFF_THR) begin
        if (bus.mmio_wstrb[0]) rx_thr <= bus.mmio_wdata[7:0];
        if (bus.mmio_wstrb[1]) tx_thr <= bus.mmio_wdata[15:8];
      end
    end
  end

  // FIFO pointers; a flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0; tx_rp <= '0; rx_wp <= '0; rx_rp <= '0;
    end else begin
      if (tx_flush) begin
        tx_wp <= '0; tx_rp <= '0;
      end else begin
        if (tx_wr) tx_wp <= tx_wp + 1'b1;
        if (trmt)  tx_rp <= tx_rp + 1'b1;
      end
      if (rx_flush) begin
        rx_wp <= '0; rx_rp <= '0;
      end else begin
        if (rx_wr)  rx_wp <= rx_wp + 1'b1;
        if (rx_pop) rx_rp <= rx_rp + 1'b1;
      end
    end
  end

  // FIFO storage (data only, never reset).
  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem[tx_wp[TXA-1:0]] <= bus.mmio_wdata[7:0];
    if (rx_wr) rx_mem[rx_wp[RXA-1:0]] <= rx_data;
  end

  // Core transmitter: 8N1 frame, baud_div+1 clocks per bit, idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0; tx_sh <= '1; tx_bits <= 4'd0; tx_tmr <= '0;
    end else if (trmt) begin
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, tx_mem[tx_rp[TXA-1:0]], 1'b0};
      tx_bits <= 4'd10;
      tx_tmr  <= baud_div;
    end else if (tx_busy) begin
      if (tx_tmr == '0) begin
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_tmr  <= baud_div;
        tx_bits <= tx_bits - 1'b1;
        if (tx_bits == 4'd1) tx_busy <= 1'b0;
      end else begin
        tx_tmr <= tx_tmr - 1'b1;
      end
    end
  end
  assign tx_ready  = ~tx_busy;
  assign tx_line   = tx_sh[0];
  assign uart_tx_o = loopback ? 1'b1 : tx_line;
  assign rx_in     = loopback ? tx_line : uart_rx_i;

  // Core receiver next-state: mid-bit sampling driven off the start edge.
  always_comb begin
    rx_state_d = rx_state;
    rx_tmr_d   = rx_tmr;
    rx_bit_d   = rx_bit;
    rx_sh_d    = rx_sh;
    rx_done    = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (!rx_s2) begin
        rx_state_d = RX_START;
        rx_tmr_d   = baud_div >> 1;
      end
      RX_START: if (rx_tmr != '0) rx_tmr_d = rx_tmr - 1'b1;
        else if (!rx_s2) begin
          rx_state_d = RX_DATA; rx_tmr_d = baud_div; rx_bit_d = 3'd0;
        end else rx_state_d = RX_IDLE;
      RX_DATA: if (rx_tmr != '0) rx_tmr_d = rx_tmr - 1'b1;
        else begin
          rx_sh_d  = {rx_s2, rx_sh[7:1]};
          rx_tmr_d = baud_div;
          rx_bit_d = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end
      RX_STOP: if (rx_tmr != '0) rx_tmr_d = rx_tmr - 1'b1;
        else begin
          rx_state_d = RX_IDLE;
          rx_done    = rx_s2;
        end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Core receiver registers, input synchroniser and rx_rdy handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE; rx_tmr <= '0; rx_bit <= 3'd0; rx_sh <= 8'd0;
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_rdy <= 1'b0; rx_data <= 8'd0;
    end else begin
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_d;
      rx_tmr   <= rx_tmr_d;
      rx_bit   <= rx_bit_d;
      rx_sh    <= rx_sh_d;
      rx_rdy   <= rx_done | (rx_rdy & ~clr_rx_rdy);
      if (rx_done) rx_data <= rx_sh;
    end
  end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Self-checking bench for uart_fifo_mmio against a queue-based model.
module tb_uart_fifo_mmio;
  localparam int BD  = 4;
  localparam int BIT = BD + 1;
  localparam logic [7:0] A_DATA = 8'h00, A_STAT = 8'h04, A_CTRL = 8'h08,
                         A_BAUD = 8'h0C, A_LVL = 8'h10, A_THR = 8'h14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx_i = 1'b1;
  logic uart_tx_o, irq_o;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] exp_frames[$];
  logic [7:0] tx_seen[$];
  logic rx_ovr_m = 1'b0, tx_ovf_m = 1'b0;
  logic [6:0] ctrl_m = 7'h03;
  logic [15:0] thr_m = 16'h0001;
  logic trmt_prev = 1'b0;

  always #5 clk = ~clk;

  uart_fifo_mmio_if #(.ADDR_W(8)) bus ();

  uart_fifo_mmio #(.ADDR_W(8), .TX_DEPTH(16), .RX_DEPTH(16), .BAUD_DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .bus(bus), .irq_o(irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.mmio_valid = 1'b1; bus.mmio_we = 1'b1; bus.mmio_addr = a;
    bus.mmio_wdata = d; bus.mmio_wstrb = s;
    @(posedge clk); #1;
    bus.mmio_valid = 1'b0; bus.mmio_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.mmio_valid = 1'b1; bus.mmio_we = 1'b0; bus.mmio_addr = a;
    #1 d = bus.mmio_rdata;
    @(posedge clk); #1;
    bus.mmio_valid = 1'b0;
  endtask

  function automatic logic [31:0] status_model();
    return {26'd0, tx_ovf_m, rx_ovr_m, rxq.size() == 16, txq.size() == 16,
            txq.size() == 0, rxq.size() != 0};
  endfunction

  function automatic logic irq_model();
    int thr;
    thr = (thr_m[7:0] == 8'd0) ? 1 : int'(thr_m[7:0]);
    return (ctrl_m[2] && rxq.size() >= thr) || (ctrl_m[3] && txq.size() <= int'(thr_m[15:8]));
  endfunction

  task automatic wr_ctrl(input logic [6:0] v);
    wr(A_CTRL, {25'd0, v}, 4'b0001);
    ctrl_m = v & 7'h4F;
  endtask

  task automatic st_chk(input string tag);
    logic [31:0] d;
    rd(A_STAT, d);
    chk(tag, d, status_model());
    rx_ovr_m = 1'b0; tx_ovf_m = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] d, e;
    e = 32'd0;
    if (rxq.size() != 0) e = {24'd0, rxq.pop_front()};
    rd(A_DATA, d);
    chk(tag, d, e);
  endtask

  // Drives one 8N1 frame on uart_rx_i; the model decides push or overrun.
  task automatic send_byte(input logic [7:0] b, input logic model);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = f[i];
      repeat (BIT) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    if (model && ctrl_m[1]) begin
      if (rxq.size() < 16) rxq.push_back(b);
      else rx_ovr_m = 1'b1;
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    wr(A_DATA, {24'd0, b}, 4'b0001);
    if (txq.size() < 16) txq.push_back(b);
    else tx_ovf_m = 1'b1;
  endtask

  // Serial decoder on uart_tx_o; frames overlapping a reset are discarded.
  always begin : tx_mon
    logic [7:0] b;
    logic ok;
    @(negedge clk);
    if (rst_n && uart_tx_o === 1'b0) begin
      ok = 1'b1;
      b = 8'd0;
      for (int k = 0; k < BIT/2; k++) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
      for (int i = 0; i < 9; i++) begin
        for (int k = 0; k < BIT; k++) begin @(negedge clk); if (!rst_n) ok = 1'b0; end
        if (i < 8) b[i] = uart_tx_o;
        else if (ok) chk("tx_stop_bit", {31'd0, uart_tx_o}, 32'd1);
      end
      if (ok) tx_seen.push_back(b);
    end
  end

  // The launch strobe must never be high in two consecutive cycles.
  always @(posedge clk) begin
    if (dut.trmt) chk("trmt_b2b", {31'd0, trmt_prev}, 32'd0);
    trmt_prev <= dut.trmt;
  end

  initial begin
    logic [31:0] d;
    logic [7:0] b, pend;
    bus.mmio_valid = 1'b0; bus.mmio_we = 1'b0; bus.mmio_addr = 8'd0;
    bus.mmio_wdata = 32'd0; bus.mmio_wstrb = 4'd0;
    repeat (3) @(posedge clk); #1;
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_txo", {31'd0, uart_tx_o}, 32'd1);
    chk("rst_ready", {31'd0, bus.mmio_ready}, 32'd1);
    rst_n = 1'b1;
    st_chk("rst_status");
    rd(A_CTRL, d);  chk("rst_ctrl", d, 32'h3);
    rd(A_LVL, d);   chk("rst_lvl", d, 32'h0);
    rd(A_THR, d);   chk("rst_thr", d, 32'h0001);
    rd(A_BAUD, d);  chk("rst_baud", d, 32'h0);
    wr(8'h18, 32'hFFFF_FFFF, 4'hF);
    rd(8'h18, d);   chk("unmapped_rd", d, 32'h0);
    wr(A_BAUD, 32'hABCD_1234, 4'b0001);
    rd(A_BAUD, d);  chk("baud_strobe", d, 32'h34);
    wr(A_BAUD, BD, 4'hF);
    rd(A_BAUD, d);  chk("baud_full", d, BD);

    // T1 loopback
    wr_ctrl(7'h43);
    rd(A_CTRL, d);  chk("lb_ctrl", d, 32'h43);
    for (int i = 0; i < 5; i++) begin
      b = (i == 0) ? 8'h55 : (i == 1) ? 8'hA3 : (i == 2) ? 8'h0F : 8'($urandom_range(0, 255));
      wr(A_DATA, {24'd0, b}, 4'b0001);
      rxq.push_back(b);
    end
    for (int i = 0; i < 2000; i++) begin rd(A_LVL, d); if (d == 32'd5) break; end
    chk("lb_lvl", d, 32'd5);
    chk("lb_txo_high", {31'd0, uart_tx_o}, 32'd1);
    chk("lb_no_frames", tx_seen.size(), 32'd0);
    for (int i = 0; i < 5; i++) rd_data("lb_data");
    rd(A_LVL, d);   chk("lb_lvl_empty", d, 32'd0);
    wr_ctrl(7'h03);

    // T2 RX overrun
    for (int i = 0; i < 17; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    rd(A_LVL, d);   chk("ovr_lvl", d, 32'd16);
    for (int i = 0; i < 16; i++) rd_data("ovr_data");
    st_chk("ovr_status_set");
    st_chk("ovr_status_clr");
    rd_data("empty_data");
    rd(A_LVL, d);   chk("empty_lvl", d, 32'd0);

    // T5 push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    wr_ctrl(7'h01);
    pend = 8'($urandom_range(0, 255));
    send_byte(pend, 1'b0);
    rd(A_LVL, d);   chk("pend_lvl", d, 32'd16);
    st_chk("pend_status");
    wr_ctrl(7'h03);
    rd_data("same_cyc_data");
    rxq.push_back(pend);
    rd(A_LVL, d);   chk("same_cyc_lvl", d, 32'd16);
    st_chk("same_cyc_status");
    for (int i = 0; i < 16; i++) rd_data("same_cyc_order");

    // T4 IRQ thresholds
    wr(A_THR, 32'h0000_0004, 4'b0001); thr_m = 16'h0004;
    wr_ctrl(7'h07);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      chk("irq_rx_thr", {31'd0, irq_o}, {31'd0, irq_model()});
    end
    rd_data("irq_data");
    chk("irq_rx_drop", {31'd0, irq_o}, {31'd0, irq_model()});
    for (int i = 0; i < 3; i++) rd_data("irq_drain");
    wr(A_THR, 32'h0000_0000, 4'b0001); thr_m = 16'h0000;
    chk("irq_thr0_empty", {31'd0, irq_o}, {31'd0, irq_model()});
    send_byte(8'($urandom_range(0, 255)), 1'b1);
    chk("irq_thr0_one", {31'd0, irq_o}, {31'd0, irq_model()});
    rd_data("irq_thr0_data");
    wr_ctrl(7'h0B);
    chk("irq_tx_thr", {31'd0, irq_o}, {31'd0, irq_model()});
    wr_ctrl(7'h03);
    chk("irq_off", {31'd0, irq_o}, 32'd0);

    // T3 TX overflow, then drain onto the line
    tx_seen.delete();
    wr_ctrl(7'h02);
    for (int i = 0; i < 17; i++) tx_write(8'($urandom_range(0, 255)));
    rd(A_LVL, d);   chk("txovf_lvl", d, 32'h0010_0000);
    st_chk("txovf_status_set");
    st_chk("txovf_status_clr");
    exp_frames = txq;
    txq.delete();
    wr_ctrl(7'h03);
    for (int i = 0; i < 16 * 12 * BIT + 200 && tx_seen.size() < 16; i++) @(posedge clk);
    chk("tx_frame_count", tx_seen.size(), 32'd16);
    for (int i = 0; i < 16 && i < tx_seen.size(); i++)
      chk("tx_frame_data", {24'd0, tx_seen[i]}, {24'd0, exp_frames[i]});
    repeat (4 * BIT) @(posedge clk);
    st_chk("tx_done_status");

    // T6 TX flush with a frame in flight
    tx_seen.delete();
    exp_frames.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      wr(A_DATA, {24'd0, b}, 4'b0001);
      if (i == 0) exp_frames.push_back(b);
    end
    wr(A_CTRL, 32'h13, 4'b0001);
    rd(A_LVL, d);   chk("flush_lvl", d, 32'd0);
    rd(A_CTRL, d);  chk("flush_ctrl_rd", d, 32'h3);
    repeat (14 * BIT) @(posedge clk);
    chk("flush_frames", tx_seen.size(), 32'd1);
    if (tx_seen.size() > 0) chk("flush_frame_data", {24'd0, tx_seen[0]}, {24'd0, exp_frames[0]});

    // Reset in the middle of a frame
    wr(A_DATA, {24'd0, 8'($urandom_range(0, 255))}, 4'b0001);
    repeat (3 * BIT) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txo", {31'd0, uart_tx_o}, 32'd1);
    chk("midrst_irq", {31'd0, irq_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rxq.delete(); txq.delete(); rx_ovr_m = 1'b0; tx_ovf_m = 1'b0;
    ctrl_m = 7'h03; thr_m = 16'h0001;
    st_chk("midrst_status");
    rd(A_CTRL, d);  chk("midrst_ctrl", d, 32'h3);
    rd(A_LVL, d);   chk("midrst_lvl", d, 32'h0);
    repeat (30) @(posedge clk);
    chk("midrst_no_frame", tx_seen.size(), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
